right_shift_seq: RTL and testbench
==================================

RIGHT_SHIFT_SEQ -- requirements
Module: right_shift_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width in bits.
REQ-002 SHALL have port clk, input, 1 bit, single clock; all state updates on its rising edge.
REQ-003 SHALL have port clr_n, input, 1 bit; reset is asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit, request a shift; sampled only in IDLE.
REQ-005 SHALL have port a, input, WIDTH bits, operand; captured on the accepting edge.
REQ-006 SHALL have port amt, input, 4 bits, shift amount 0..15; captured on the accepting edge.
REQ-007 SHALL have port arith, input, 1 bit; 1 selects arithmetic (sign-fill), 0 selects logical (zero-fill); captured on the accepting edge.
REQ-008 SHALL have port y, output, WIDTH bits, result register.
REQ-009 SHALL have port cout, output, 1 bit, last bit shifted out.
REQ-010 SHALL have port busy, output, 1 bit, high whenever state is not IDLE.
REQ-011 SHALL have port done, output, 1 bit, one-cycle completion pulse.

Function
REQ-012 SHALL implement three states: IDLE, SHIFT, DONE.
REQ-013 In IDLE with start=1 at a rising edge (the accepting edge, edge 0), SHALL load work register = a, count = amt, fill bit = arith & a[WIDTH-1], shift-out bit = 0, and go to SHIFT.
REQ-014 In SHIFT with count != 0, each edge SHALL shift the work register right by one bit, insert the fill bit at the MSB, store the old LSB as shift-out bit, and decrement count.
REQ-015 In SHIFT with count == 0, the edge SHALL copy the work register to y and the shift-out bit to cout, then go to DONE.
REQ-016 DONE SHALL be entered at edge amt+1; done SHALL be high exactly one cycle (DONE state); the next edge SHALL return to IDLE.
REQ-017 y and cout SHALL hold their values from DONE until the next completion or reset.
REQ-018 start SHALL be ignored in SHIFT and DONE; no queuing.
REQ-019 Changes on a, amt or arith after the accepting edge SHALL NOT affect the in-flight result.
REQ-020 amt=0 SHALL give y=a and cout=0, with done at edge 1.
REQ-021 With amt=15 and arith=1, y SHALL be all copies of a[WIDTH-1].
REQ-022 busy SHALL be low only in IDLE; done SHALL never be high in IDLE or SHIFT.

Reset
REQ-023 clr_n low SHALL immediately force state=IDLE, y=0, cout=0, busy=0, done=0, count=0, and clear the work register, regardless of clk.
REQ-024 Reset asserted mid-SHIFT SHALL abort the operation with no done pulse; the first start after clr_n rises SHALL be accepted normally.

Structure
REQ-025 A shared package shift_pkg SHALL hold the state enum (IDLE/SHIFT/DONE), DATA_W=16 and CNT_W=4.
REQ-026 The block SHALL be a single module with no sub-module; next-state logic and datapath registers are kept separate.

Verification
REQ-027 a=16'd50, amt=1, arith=0 -> y=16'd25, cout=0, done at edge 2.
REQ-028 a=16'd1250, amt=3, arith=0 -> y=16'd156, cout=0, done at edge 4, busy high edges 0..4.
REQ-029 a=16'h8000, amt=15, arith=1 -> y=16'hFFFF, cout=0; with arith=0 -> y=16'h0001.
REQ-030 a=16'h1234, amt=0 -> y=16'h1234, cout=0, done at edge 1; also a=16'h0007, amt=2, arith=0 -> y=16'h0001, cout=1.
REQ-031 Pulse start again with a=16'hFFFF during SHIFT -> ignored; the original result is unchanged and only one done pulse is produced.
REQ-032 Drive clr_n low mid-SHIFT -> y=0, busy=0 asynchronously, no done; a new start after release completes correctly.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types and sizes for the sequential right shifter.
package shift_pkg;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : shift_pkg

// File: rtl/right_shift_seq.sv
// Sequential right shifter: one bit per clock, logical or arithmetic fill,
// result and last shifted-out bit held until the next completion.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// SHIFT | shifting one bit per edge until the count reaches zero
// DONE  | result valid, done pulse for one cycle, then back to IDLE
module right_shift_seq
    import shift_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [CNT_W-1:0] amt,
    input  logic             arith,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               fill_q, fill_d;
    logic               sout_q, sout_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic               cout_q, cout_d;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (cnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    // Datapath is kept apart from the next-state logic; it only looks at state_q.
    always_comb begin
        work_d = work_q;
        cnt_d  = cnt_q;
        fill_d = fill_q;
        sout_d = sout_q;
        y_d    = y_q;
        cout_d = cout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    work_d = a;
                    cnt_d  = amt;
                    fill_d = arith & a[WIDTH-1];
                    sout_d = 1'b0;
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    work_d = {fill_q, work_q[WIDTH-1:1]};
                    sout_d = work_q[0];
                    cnt_d  = cnt_q - CNT_W'(1);
                end else begin
                    y_d    = work_q;
                    cout_d = sout_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            work_q <= '0;
            cnt_q  <= '0;
            fill_q <= 1'b0;
            sout_q <= 1'b0;
            y_q    <= '0;
            cout_q <= 1'b0;
        end else begin
            work_q <= work_d;
            cnt_q  <= cnt_d;
            fill_q <= fill_d;
            sout_q <= sout_d;
            y_q    <= y_d;
            cout_q <= cout_d;
        end
    end

    assign y    = y_q;
    assign cout = cout_q;

endmodule : right_shift_seq

// File: tb/tb_right_shift_seq.sv
// Directed bench for right_shift_seq: vector table plus corner-case sequences.
module tb_right_shift_seq;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        start;
    logic [15:0] a;
    logic [3:0]  amt;
    logic        arith;
    logic [15:0] y;
    logic        cout;
    logic        busy;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    right_shift_seq dut (
        .clk   (clk),
        .clr_n (clr_n),
        .start (start),
        .a     (a),
        .amt   (amt),
        .arith (arith),
        .y     (y),
        .cout  (cout),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [3:0]  amt;
        logic        arith;
        logic [15:0] exp_y;
        logic        exp_cout;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Launches one operation, scrambles the operands after acceptance and
    // checks latency, busy/done behaviour and the held result.
    task automatic do_op(input string name, input logic [15:0] ia, input logic [3:0] iamt,
                         input logic iarith, input logic [15:0] ey, input logic ec);
        int e;
        int busy_bad;
        bit seen;
        @(negedge clk);
        a = ia; amt = iamt; arith = iarith; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; a = ~ia; amt = ~iamt; arith = ~iarith;
        e = 0; busy_bad = 0; seen = 0;
        while (!seen && e < 40) begin
            @(negedge clk);
            if (!busy) busy_bad++;
            if (done) seen = 1;
            else e++;
        end
        check({name, " done_edge"}, e, {28'd0, iamt} + 32'd1);
        check({name, " busy_low_in_flight"}, busy_bad, 0);
        check({name, " y"}, y, ey);
        check({name, " cout"}, cout, ec);
        @(negedge clk);
        check({name, " idle_after"}, {busy, done}, 2'b00);
        check({name, " y_hold"}, y, ey);
    endtask

    initial begin
        int pulses;
        vecs[0] = '{16'd50,   4'd1,  1'b0, 16'd25,   1'b0};
        vecs[1] = '{16'd1250, 4'd3,  1'b0, 16'd156,  1'b0};
        vecs[2] = '{16'h8000, 4'd15, 1'b1, 16'hFFFF, 1'b0};
        vecs[3] = '{16'h8000, 4'd15, 1'b0, 16'h0001, 1'b0};
        vecs[4] = '{16'h1234, 4'd0,  1'b0, 16'h1234, 1'b0};
        vecs[5] = '{16'h0007, 4'd2,  1'b0, 16'h0001, 1'b1};
        vecs[6] = '{16'hF0F0, 4'd4,  1'b1, 16'hFF0F, 1'b0};
        vecs[7] = '{16'h8001, 4'd1,  1'b1, 16'hC000, 1'b1};

        clr_n = 1'b0; start = 1'b0; a = '0; amt = '0; arith = 1'b0;
        #12;
        check("reset y", y, 0);
        check("reset cout_busy_done", {cout, busy, done}, 3'b000);
        @(negedge clk);
        clr_n = 1'b1;

        for (int i = 0; i < 8; i++)
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].amt, vecs[i].arith,
                  vecs[i].exp_y, vecs[i].exp_cout);

        // start re-pulsed during SHIFT must be ignored
        @(negedge clk);
        a = 16'h1234; amt = 4'd5; arith = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 16'hFFFF; amt = 4'd0;
        @(negedge clk);
        start = 1'b1; arith = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pulses = 0;
        for (int k = 0; k < 15; k++) begin
            if (done) pulses++;
            @(negedge clk);
        end
        check("ignore_start pulses", pulses, 1);
        check("ignore_start y", y, 16'h0091);
        check("ignore_start cout", cout, 1'b1);
        check("ignore_start idle", busy, 1'b0);

        // asynchronous reset mid-SHIFT aborts without a done pulse
        @(negedge clk);
        a = 16'h00F0; amt = 4'd10; arith = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_abort busy", busy, 1'b1);
        #2;
        clr_n = 1'b0;
        #1;
        check("abort y", y, 0);
        check("abort busy_done_cout", {busy, done, cout}, 3'b000);
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        clr_n = 1'b1;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        check("abort no_activity", pulses, 0);
        do_op("after_reset", 16'd1250, 4'd3, 1'b0, 16'd156, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule : tb_right_shift_seq
